det3_macc_sequencer: RTL and testbench
======================================

// Module: det3_macc_sequencer
// PURPOSE
//  Initiator side of the MACC3 interface: accepts a 3x3 matrix as a 9-word serial stream,
//  issues the six signed triple products of the determinant to an external MACC3 unit,
//  collects the accumulated result and emits it with a one-cycle sync strobe.
//  Sits between the stream source and one MACC3 instance.
// PARAMETERS
//  WIDTH     16  data width of in, out and MACC3 operands/result (signed, two's complement)
//  MACC_LAT  2   edges from MACC3 sampling an op until MACC3_0_Y holds the updated sum (>=1)
// PORTS
//  clk            in   1      single clock, all logic on posedge
//  rst            in   1      asynchronous, active-low reset (rst==0 resets)
//  sync_in        out  1      high in the cycle element 0 of a matrix is sampled from in
//  in             in   WIDTH  matrix element stream, row-major a,b,c,d,e,f,g,h,i
//  MACC3_0_A      out  WIDTH  MACC3 operand A
//  MACC3_0_B      out  WIDTH  MACC3 operand B
//  MACC3_0_C      out  WIDTH  MACC3 operand C
//  MACC3_0_clear  out  1      op restarts accumulation from 0
//  MACC3_0_sub    out  1      op subtracts product instead of adding
//  MACC3_0_Y      in   WIDTH  MACC3 accumulated result
//  sync_out       out  1      one-cycle strobe: out holds a new determinant this cycle
//  out            out  WIDTH  determinant, held until the next result
// BEHAVIOUR
//  - Reset: all outputs 0, FSM -> IDLE, element/op/wait counters 0; aborts any matrix in flight.
//  - FSM: IDLE (1 cycle after reset release) -> LOAD (9 cycles) -> ISSUE (6) -> WAIT (MACC_LAT)
//    -> EMIT (1) -> LOAD. sync_in=1 only in LOAD cycle 0; elements 1..8 sampled on the next 8
//    edges unconditionally (no stall, no valid).
//  - ISSUE ops, one per cycle, all outputs registered; clear=1 only on op0, sub=1 on ops 3-5:
//    op0 a,e,i +; op1 b,f,g +; op2 c,d,h +; op3 c,e,g -; op4 b,d,i -; op5 a,f,h -.
//  - Outside ISSUE: A/B/C=0, clear=0, sub=0 (MACC3 accumulates 0, sum unaffected).
//  - WAIT: counts MACC_LAT cycles; at the end of the last one MACC3_0_Y is captured into out.
//    EMIT: sync_out=1 for exactly that cycle; out unchanged until next capture.
//  - Latency (sync_in cycle = 0): ISSUE cycles 9-14, capture at end of cycle 14+MACC_LAT,
//    sync_out in cycle 15+MACC_LAT (17 for default); next sync_in in cycle 16+MACC_LAT.
//  - Arithmetic: no widening; products and sum wrap modulo 2^WIDTH inside MACC3; out is
//    MACC3_0_Y bit-exact. Sequencer does no arithmetic of its own.
//  - Reset asserted mid-LOAD/ISSUE/WAIT: no sync_out for that matrix; restart at IDLE;
//    MACC3 state irrelevant because next op0 carries clear=1.
// CONFIGURATION
//  DET3_SEQ_OVERLAP_EN defined: two matrix register banks; LOAD of matrix n+1 starts the cycle
//    after LOAD of n ends (sync_in every 9 cycles). ISSUE of n+1 starts after ISSUE of n ends and
//    its LOAD completes. Capture/strobe of n independent of issue of n+1 (MACC_LAT <= 3
//    required: result of n read before op0 of n+1 reaches MACC3_0_Y). Steady state: one
//    sync_out per 9 cycles.
//  Not defined: single bank, strictly serial FSM above; one result per 16+MACC_LAT cycles.
// TESTING (bench pairs this block with a behavioural MACC3 of matching MACC_LAT)
//  - Stream 4,7,5,2,6,4,9,2,1 -> sync_out 17 cycles after sync_in, out=-20; op trace exactly
//    as ISSUE table, clear only on op0.
//  - All-zero matrix after previous -20 result -> out=0 (clear verified), sync_out single cycle.
//  - 200,0,0,0,200,0,0,0,2 -> out=14464 (80000 mod 65536, wrap, no saturation).
//  - Identity then -identity (-1 diag) -> out=1 then out=-1; out held steady between strobes.
//  - rst low during ISSUE op3 -> all outputs 0 immediately, no sync_out, next matrix
//    4,7,5,2,6,4,9,2,1 -> -20.
//  - With DET3_SEQ_OVERLAP_EN: four back-to-back matrices -> sync_in and sync_out every 9 cycles,
//    results in order; without it -> period 18 cycles.

Source files
------------

// File: rtl/det3_macc_sequencer_if.sv
// ---------------------------------------------------------------------------
// det3_macc_sequencer_if
//   Operand/result bus between the determinant sequencer and one MACC3 unit.
//   The hierarchical names (MACC3_0.A, MACC3_0.clear, ...) mirror the flat
//   MACC3_0_* port names of the unit.
//
//   A, B, C  operands of one triple product (WIDTH bits, two's complement)
//   clear    this op restarts the accumulation from 0
//   sub      this op subtracts its product instead of adding it
//   Y        accumulated result returned by MACC3
//
//   master : sequencer side (drives operands, reads Y)
//   slave  : MACC3 side (reads operands, drives Y)
// ---------------------------------------------------------------------------
interface det3_macc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             clear;
  logic             sub;
  logic [WIDTH-1:0] Y;

  modport master (output A, B, C, clear, sub, input Y);
  modport slave  (input A, B, C, clear, sub, output Y);
endinterface

// File: rtl/det3_macc_sequencer.sv
// ---------------------------------------------------------------------------
// det3_macc_sequencer
//   Takes a 3x3 matrix as a 9-word row-major stream (a..i), issues the six
//   signed triple products of its determinant to an external MACC3 unit,
//   captures the accumulated result and presents it with a one-cycle strobe.
//
// Parameters
//   WIDTH     data width of in, out and the MACC3 operands/result
//   MACC_LAT  edges from MACC3 sampling an op until Y holds the updated sum
//
// Ports
//   clk        clock, all logic on posedge
//   rst        asynchronous active-low reset
//   sync_in    high in the cycle element 0 of a matrix is sampled from in
//   in         matrix element stream
//   MACC3_0    MACC3 operand/result bus (master side)
//   sync_out   one-cycle strobe: out holds a new determinant this cycle
//   out        determinant, held until the next capture
//   dbg_state  current FSM state (state_t encoding), for observation only
//
// Stream protocol: there is no valid/ready. The source must present element 0
// in the cycle sync_in is high and elements 1..8 on the following 8 cycles;
// every element is sampled unconditionally. sync_out is a pure strobe with no
// back-pressure; out stays stable until the next strobe.
//
// Configuration macro DET3_SEQ_OVERLAP_EN
//   undefined: single matrix bank, strictly serial
//              IDLE -> LOAD(9) -> ISSUE(6) -> WAIT(MACC_LAT) -> EMIT -> LOAD.
//   defined:   two banks; loading runs continuously (sync_in every 9 cycles)
//              and issue/capture of matrix n overlap the load of n+1.
//              Requires MACC_LAT <= 3 so the result of n is captured before
//              op0 of n+1 reaches Y.
// ---------------------------------------------------------------------------
module det3_macc_sequencer #(
  parameter int WIDTH    = 16,
  parameter int MACC_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 sync_in,
  input  logic [WIDTH-1:0]     in,
  det3_macc_sequencer_if.master MACC3_0,
  output logic                 sync_out,
  output logic [WIDTH-1:0]     out,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4
  } state_t;

  localparam int             WCW       = (MACC_LAT > 1) ? $clog2(MACC_LAT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MACC_LAT - 1);

  state_t                  state;
  logic [3:0]              elem_cnt;
  logic [2:0]              op_cnt;
  logic [WCW-1:0]          wait_cnt;
  logic                    load_last;
  logic [8:0][WIDTH-1:0]   cur_mat;
  logic [8:0][WIDTH-1:0]   op_mat;
  logic [2:0]              nxt_op;
  logic [WIDTH-1:0]        nxt_a, nxt_b, nxt_c;
  logic                    nxt_clear, nxt_sub;

  assign dbg_state = state;
  assign load_last = (state == S_LOAD) && (elem_cnt == 4'd8);

  // Operands of the op to be registered at the coming edge. op0 is loaded on
  // the same edge that samples element i, so i is taken straight from in.
  always_comb begin
    op_mat = cur_mat;
    if (load_last) op_mat[8] = in;
    nxt_op    = load_last ? 3'd0 : op_cnt + 3'd1;
    nxt_a     = '0;
    nxt_b     = '0;
    nxt_c     = '0;
    nxt_clear = 1'b0;
    nxt_sub   = 1'b0;
    case (nxt_op)
      // a*e*i, restarts the sum
      3'd0: begin nxt_a = op_mat[0]; nxt_b = op_mat[4]; nxt_c = op_mat[8]; nxt_clear = 1'b1; end
      // b*f*g
      3'd1: begin nxt_a = op_mat[1]; nxt_b = op_mat[5]; nxt_c = op_mat[6]; end
      // c*d*h
      3'd2: begin nxt_a = op_mat[2]; nxt_b = op_mat[3]; nxt_c = op_mat[7]; end
      // -c*e*g
      3'd3: begin nxt_a = op_mat[2]; nxt_b = op_mat[4]; nxt_c = op_mat[6]; nxt_sub = 1'b1; end
      // -b*d*i
      3'd4: begin nxt_a = op_mat[1]; nxt_b = op_mat[3]; nxt_c = op_mat[8]; nxt_sub = 1'b1; end
      // -a*f*h
      3'd5: begin nxt_a = op_mat[0]; nxt_b = op_mat[5]; nxt_c = op_mat[7]; nxt_sub = 1'b1; end
      default: ;
    endcase
  end

`ifdef DET3_SEQ_OVERLAP_EN

  logic [1:0][8:0][WIDTH-1:0] bank;
  logic                       wr_bank;
  logic                       rd_bank;
  logic                       issuing;
  logic                       waiting;

  // During the last load cycle the bank being filled is the one about to be
  // issued; afterwards the issue engine reads the bank it latched.
  assign cur_mat = load_last ? bank[wr_bank] : bank[rd_bank];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      elem_cnt   <= '0;
      op_cnt     <= '0;
      wait_cnt   <= '0;
      bank       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      issuing    <= 1'b0;
      waiting    <= 1'b0;
      sync_in    <= 1'b0;
      sync_out   <= 1'b0;
      out        <= '0;
      MACC3_0.A     <= '0;
      MACC3_0.B     <= '0;
      MACC3_0.C     <= '0;
      MACC3_0.clear <= 1'b0;
      MACC3_0.sub   <= 1'b0;
    end else begin
      sync_in  <= 1'b0;
      sync_out <= 1'b0;

      // Loader: never stalls, restarts immediately into the other bank.
      case (state)
        S_IDLE: begin
          state    <= S_LOAD;
          elem_cnt <= '0;
          sync_in  <= 1'b1;
        end
        S_LOAD: begin
          bank[wr_bank][elem_cnt] <= in;
          if (load_last) begin
            elem_cnt <= '0;
            sync_in  <= 1'b1;
            wr_bank  <= ~wr_bank;
            rd_bank  <= wr_bank;
          end else begin
            elem_cnt <= elem_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Issue engine: six ops take fewer cycles than a load, so it is always
      // idle when the next bank completes.
      if (load_last) begin
        issuing       <= 1'b1;
        op_cnt        <= '0;
        MACC3_0.A     <= nxt_a;
        MACC3_0.B     <= nxt_b;
        MACC3_0.C     <= nxt_c;
        MACC3_0.clear <= nxt_clear;
        MACC3_0.sub   <= nxt_sub;
      end else if (issuing) begin
        if (op_cnt == 3'd5) begin
          issuing       <= 1'b0;
          waiting       <= 1'b1;
          wait_cnt      <= '0;
          MACC3_0.A     <= '0;
          MACC3_0.B     <= '0;
          MACC3_0.C     <= '0;
          MACC3_0.clear <= 1'b0;
          MACC3_0.sub   <= 1'b0;
        end else begin
          op_cnt        <= op_cnt + 3'd1;
          MACC3_0.A     <= nxt_a;
          MACC3_0.B     <= nxt_b;
          MACC3_0.C     <= nxt_c;
          MACC3_0.clear <= nxt_clear;
          MACC3_0.sub   <= nxt_sub;
        end
      end

      // Capture: runs in the shadow of the next matrix's load.
      if (waiting) begin
        if (wait_cnt == WAIT_LAST) begin
          out      <= MACC3_0.Y;
          sync_out <= 1'b1;
          waiting  <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

`else

  logic [8:0][WIDTH-1:0] mat;

  assign cur_mat = mat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      elem_cnt   <= '0;
      op_cnt     <= '0;
      wait_cnt   <= '0;
      mat        <= '0;
      sync_in    <= 1'b0;
      sync_out   <= 1'b0;
      out        <= '0;
      MACC3_0.A     <= '0;
      MACC3_0.B     <= '0;
      MACC3_0.C     <= '0;
      MACC3_0.clear <= 1'b0;
      MACC3_0.sub   <= 1'b0;
    end else begin
      sync_in  <= 1'b0;
      sync_out <= 1'b0;
      case (state)
        S_IDLE: begin
          state    <= S_LOAD;
          elem_cnt <= '0;
          sync_in  <= 1'b1;
        end
        S_LOAD: begin
          mat[elem_cnt] <= in;
          if (load_last) begin
            state         <= S_ISSUE;
            op_cnt        <= '0;
            MACC3_0.A     <= nxt_a;
            MACC3_0.B     <= nxt_b;
            MACC3_0.C     <= nxt_c;
            MACC3_0.clear <= nxt_clear;
            MACC3_0.sub   <= nxt_sub;
          end else begin
            elem_cnt <= elem_cnt + 4'd1;
          end
        end
        S_ISSUE: begin
          if (op_cnt == 3'd5) begin
            // Zero operands: MACC3 keeps accumulating 0, sum unaffected.
            state         <= S_WAIT;
            wait_cnt      <= '0;
            MACC3_0.A     <= '0;
            MACC3_0.B     <= '0;
            MACC3_0.C     <= '0;
            MACC3_0.clear <= 1'b0;
            MACC3_0.sub   <= 1'b0;
          end else begin
            op_cnt        <= op_cnt + 3'd1;
            MACC3_0.A     <= nxt_a;
            MACC3_0.B     <= nxt_b;
            MACC3_0.C     <= nxt_c;
            MACC3_0.clear <= nxt_clear;
            MACC3_0.sub   <= nxt_sub;
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            out      <= MACC3_0.Y;
            sync_out <= 1'b1;
            state    <= S_EMIT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_EMIT: begin
          state    <= S_LOAD;
          elem_cnt <= '0;
          sync_in  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_det3_macc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_det3_macc_sequencer
//   Directed bench for det3_macc_sequencer paired with a behavioural MACC3 of
//   matching latency. Expected determinants are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_det3_macc_sequencer;
  localparam int WIDTH    = 16;
  localparam int MACC_LAT = 2;
  localparam int LAT_OUT  = 15 + MACC_LAT;   // sync_in cycle -> sync_out cycle
`ifdef DET3_SEQ_OVERLAP_EN
  localparam int PERIOD   = 9;
`else
  localparam int PERIOD   = 16 + MACC_LAT;
`endif

  typedef logic [8:0][WIDTH-1:0] mat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] in_d = '0;
  logic             sync_in;
  logic             sync_out;
  logic [WIDTH-1:0] out;
  logic [2:0]       dbg_state;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               exp_cyc_q[$];

  det3_macc_sequencer_if #(.WIDTH(WIDTH)) bus ();

  det3_macc_sequencer #(.WIDTH(WIDTH), .MACC_LAT(MACC_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .sync_in   (sync_in),
    .in        (in_d),
    .MACC3_0   (bus),
    .sync_out  (sync_out),
    .out       (out),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural MACC3 ----------------
  // acc_q[0] is updated on the sampling edge; Y appears MACC_LAT edges later
  // counting that edge.
  logic [WIDTH-1:0] acc_q [MACC_LAT] = '{default: '0};
  logic [WIDTH-1:0] prod, base, acc_nxt;

  always_comb begin
    prod    = bus.A * bus.B * bus.C;
    base    = bus.clear ? '0 : acc_q[0];
    acc_nxt = bus.sub ? base - prod : base + prod;
  end

  always @(posedge clk) begin
    acc_q[0] <= acc_nxt;
    for (int k = 1; k < MACC_LAT; k++) acc_q[k] <= acc_q[k-1];
  end

  assign bus.Y = acc_q[MACC_LAT-1];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic mat_t mk(input int a, b, c, d, e, f, g, h, i);
    mat_t m;
    m[0] = WIDTH'(a); m[1] = WIDTH'(b); m[2] = WIDTH'(c);
    m[3] = WIDTH'(d); m[4] = WIDTH'(e); m[5] = WIDTH'(f);
    m[6] = WIDTH'(g); m[7] = WIDTH'(h); m[8] = WIDTH'(i);
    return m;
  endfunction

  // Waits (bounded) for sync_in, then presents the 9 elements. Returns in
  // cycle 8 of the matrix; c0 is the cycle number of the sync_in cycle.
  task automatic drive_matrix(input mat_t m, output bit ok, output int c0);
    ok = 1'b0;
    c0 = -1;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (sync_in === 1'b1) ok = 1'b1;
      else tick();
    end
    if (ok) begin
      c0   = cyc;
      in_d = m[0];
      for (int k = 1; k < 9; k++) begin
        tick();
        in_d = m[k];
      end
    end
  endtask

  task automatic wait_sync_out(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (sync_out === 1'b1) seen = 1'b1;
      else tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst  = 1'b0;
    in_d = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({sync_in, sync_out, bus.clear, bus.sub} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: sync_in=%b sync_out=%b clear=%b sub=%b, want all 0",
               sync_in, sync_out, bus.clear, bus.sub);
    end
    n_checks++;
    if (out !== '0) begin
      n_fail++; $display("FAIL reset_out: out=%0d, want 0", out);
    end
    n_checks++;
    if ({bus.A, bus.B, bus.C} !== '0) begin
      n_fail++; $display("FAIL reset_ops: A=%0d B=%0d C=%0d, want 0", bus.A, bus.B, bus.C);
    end
    n_checks++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: state=%0d, want 0 (IDLE)", dbg_state);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (sync_in !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle_len: sync_in=%b one cycle after release, want 1", sync_in);
    end
  endtask

  task automatic test_basic();
    int         ea[6] = '{4, 7, 5, 5, 7, 4};
    int         eb[6] = '{6, 4, 2, 6, 2, 4};
    int         ec[6] = '{1, 9, 2, 9, 1, 2};
    logic [5:0] eclr  = 6'b000001;   // bit k = op k
    logic [5:0] esub  = 6'b111000;
    bit ok, seen;
    int c0;
    drive_matrix(mk(4, 7, 5, 2, 6, 4, 9, 2, 1), ok, c0);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_sync_in: none within 40 cycles, want one"); end
    tick();
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (bus.A !== WIDTH'(ea[k]) || bus.B !== WIDTH'(eb[k]) || bus.C !== WIDTH'(ec[k]) ||
          bus.clear !== eclr[k] || bus.sub !== esub[k]) begin
        n_fail++;
        $display("FAIL basic_op%0d: A=%0d B=%0d C=%0d clear=%b sub=%b, want %0d %0d %0d %b %b",
                 k, bus.A, bus.B, bus.C, bus.clear, bus.sub, ea[k], eb[k], ec[k], eclr[k], esub[k]);
      end
      tick();
    end
    n_checks++;
    if ({bus.A, bus.B, bus.C, bus.clear, bus.sub} !== '0) begin
      n_fail++;
      $display("FAIL basic_bus_idle: A=%0d B=%0d C=%0d clear=%b sub=%b after ISSUE, want 0",
               bus.A, bus.B, bus.C, bus.clear, bus.sub);
    end
    wait_sync_out(seen);
    n_checks++;
    if (!seen || cyc - c0 != LAT_OUT) begin
      n_fail++; $display("FAIL basic_latency: seen=%b latency=%0d, want %0d", seen, cyc - c0, LAT_OUT);
    end
    n_checks++;
    if (out !== WIDTH'(-20)) begin
      n_fail++; $display("FAIL basic_result: out=%0d, want -20", $signed(out));
    end
    tick();
    n_checks++;
    if (sync_out !== 1'b0 || out !== WIDTH'(-20)) begin
      n_fail++; $display("FAIL basic_strobe_width: sync_out=%b out=%0d, want 0 and -20", sync_out, $signed(out));
    end
  endtask

  task automatic test_zero();
    bit ok, seen;
    int c0;
    drive_matrix(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), ok, c0);
    tick();
    wait_sync_out(seen);
    n_checks++;
    if (!ok || !seen || cyc - c0 != LAT_OUT || out !== '0) begin
      n_fail++;
      $display("FAIL zero_clear: ok=%b seen=%b latency=%0d out=%0d, want 1 1 %0d 0",
               ok, seen, cyc - c0, $signed(out), LAT_OUT);
    end
    tick();
    n_checks++;
    if (sync_out !== 1'b0) begin
      n_fail++; $display("FAIL zero_strobe_width: sync_out=%b, want 0", sync_out);
    end
  endtask

  task automatic test_wrap();
    bit ok, seen;
    int c0;
    drive_matrix(mk(200, 0, 0, 0, 200, 0, 0, 0, 2), ok, c0);
    tick();
    wait_sync_out(seen);
    n_checks++;
    if (!ok || !seen || out !== 16'd14464) begin
      n_fail++; $display("FAIL wrap_result: ok=%b seen=%b out=%0d, want 14464", ok, seen, out);
    end
  endtask

  task automatic test_identity();
    bit ok, seen, hold_bad;
    int c0;
    logic [WIDTH-1:0] held;
    drive_matrix(mk(1, 0, 0, 0, 1, 0, 0, 0, 1), ok, c0);
    tick();
    wait_sync_out(seen);
    n_checks++;
    if (!ok || !seen || out !== 16'd1) begin
      n_fail++; $display("FAIL ident_result: ok=%b seen=%b out=%0d, want 1", ok, seen, $signed(out));
    end
    tick();
    n_checks++;
    if (sync_out !== 1'b0 || out !== 16'd1) begin
      n_fail++; $display("FAIL ident_hold: sync_out=%b out=%0d, want 0 and 1", sync_out, $signed(out));
    end
    drive_matrix(mk(-1, 0, 0, 0, -1, 0, 0, 0, -1), ok, c0);
    tick();
    held     = out;
    hold_bad = 1'b0;
    seen     = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (sync_out === 1'b1) seen = 1'b1;
      else begin
        if (out !== held) hold_bad = 1'b1;
        tick();
      end
    end
    n_checks++;
    if (hold_bad) begin
      n_fail++; $display("FAIL negident_hold: out changed between strobes, want %0d held", $signed(held));
    end
    n_checks++;
    if (!ok || !seen || out !== 16'hFFFF) begin
      n_fail++; $display("FAIL negident_result: ok=%b seen=%b out=%0d, want -1", ok, seen, $signed(out));
    end
  endtask

  task automatic test_reset_mid_issue();
    bit ok, seen, strobe_bad;
    int c0;
    drive_matrix(mk(4, 7, 5, 2, 6, 4, 9, 2, 1), ok, c0);
    repeat (4) tick();   // cycle 12: op3 on the bus
    n_checks++;
    if (bus.A !== 16'd5 || bus.B !== 16'd6 || bus.C !== 16'd9 || bus.sub !== 1'b1 || bus.clear !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_op3: A=%0d B=%0d C=%0d clear=%b sub=%b, want 5 6 9 0 1",
               bus.A, bus.B, bus.C, bus.clear, bus.sub);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({sync_in, sync_out, bus.clear, bus.sub} !== 4'b0000 || {bus.A, bus.B, bus.C} !== '0 || out !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: sync_in=%b sync_out=%b A=%0d B=%0d C=%0d clear=%b sub=%b out=%0d, want all 0",
               sync_in, sync_out, bus.A, bus.B, bus.C, bus.clear, bus.sub, out);
    end
    strobe_bad = 1'b0;
    repeat (2) begin
      tick();
      if (sync_out !== 1'b0) strobe_bad = 1'b1;
    end
    rst = 1'b1;
    for (int k = 0; k < 6 && sync_in !== 1'b1; k++) begin
      if (sync_out !== 1'b0) strobe_bad = 1'b1;
      tick();
    end
    n_checks++;
    if (strobe_bad) begin
      n_fail++; $display("FAIL rstmid_no_strobe: sync_out seen for aborted matrix, want none");
    end
    drive_matrix(mk(4, 7, 5, 2, 6, 4, 9, 2, 1), ok, c0);
    tick();
    wait_sync_out(seen);
    n_checks++;
    if (!ok || !seen || cyc - c0 != LAT_OUT || out !== WIDTH'(-20)) begin
      n_fail++;
      $display("FAIL rstmid_recover: ok=%b seen=%b latency=%0d out=%0d, want 1 1 %0d -20",
               ok, seen, cyc - c0, $signed(out), LAT_OUT);
    end
  endtask

  task automatic test_back_to_back();
    mat_t             ms[4];
    logic [WIDTH-1:0] ev[4];
    int               sin_cyc[4];
    bit               ok, ok_all;
    int               c0, got;
    ms[0] = mk(4, 7, 5, 2, 6, 4, 9, 2, 1);        ev[0] = WIDTH'(-20);
    ms[1] = mk(1, 0, 0, 0, 1, 0, 0, 0, 1);        ev[1] = 16'd1;
    ms[2] = mk(200, 0, 0, 0, 200, 0, 0, 0, 2);    ev[2] = 16'd14464;
    ms[3] = mk(-1, 0, 0, 0, -1, 0, 0, 0, -1);     ev[3] = 16'hFFFF;
    exp_q.delete();
    exp_cyc_q.delete();
    ok_all = 1'b1;
    got    = 0;
    fork
      begin
        for (int j = 0; j < 4; j++) begin
          drive_matrix(ms[j], ok, c0);
          ok_all     = ok_all & ok;
          sin_cyc[j] = c0;
          exp_q.push_back(ev[j]);
          exp_cyc_q.push_back(c0 + LAT_OUT);
        end
      end
      begin
        for (int c = 0; c < 200 && got < 4; c++) begin
          tick();
          if (exp_cyc_q.size() > 0 && cyc == exp_cyc_q[0]) begin
            n_checks++;
            if (sync_out !== 1'b1 || out !== exp_q[0]) begin
              n_fail++;
              $display("FAIL b2b_result%0d: sync_out=%b out=%0d, want 1 and %0d",
                       got, sync_out, $signed(out), $signed(exp_q[0]));
            end
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
            got++;
          end
        end
      end
    join
    n_checks++;
    if (!ok_all || got != 4) begin
      n_fail++; $display("FAIL b2b_complete: drives_ok=%b results=%0d, want 1 and 4", ok_all, got);
    end
    for (int j = 1; j < 4; j++) begin
      n_checks++;
      if (sin_cyc[j] - sin_cyc[j-1] != PERIOD) begin
        n_fail++;
        $display("FAIL b2b_period%0d: sync_in spacing=%0d, want %0d", j, sin_cyc[j] - sin_cyc[j-1], PERIOD);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_wrap();
    test_identity();
    test_reset_mid_issue();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
